nios2_jtag_debug_cmd_bridge: RTL and testbench
==============================================

Name: nios2_jtag_debug_cmd_bridge

Overview:
System-clock side of the Nios II JTAG debug module, generalised: parametrised IR width, shift-register width and action-bit position, plus buffered command delivery with a ready/valid handshake.
- Synchronises the virtual-JTAG update-IR and update-DR strobes, which are asynchronous to clk.
- Captures the IR and shift register, queues each DR update as a command and emits per-IR take_action/take_no_action pulses aligned with jdo.
- Sits between the TCK-domain debug logic and the OCI (break, ocimem, trace) consumers.

Parameters:
- IR_W, 2, virtual-JTAG instruction width; number of command channels = 2**IR_W
- SR_W, 38, shift-register / jdo width
- ACT_BIT, 34, sr bit selecting action (1) vs no-action (0); must be < SR_W
- SYNC_STAGES, 2, synchroniser depth for vs_uir/vs_udr (minimum 2)
- FIFO_DEPTH, 4, command queue depth (power of 2, minimum 2); used only with the optional feature

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- vs_uir  in  1  update-IR level from the TCK domain (async)
- vs_udr  in  1  update-DR level from the TCK domain (async)
- ir_in  in  IR_W  instruction register; stable while vs_uir is high
- sr  in  SR_W  shift register; stable while vs_udr is high
- cmd_ready  in  1  consumer accepts the head command
- ovf_clr  in  1  clears the overflow flag
- cmd_valid  out  1  head command available
- cmd_ir  out  IR_W  IR of the head command
- jdo  out  SR_W  data of the last popped command (registered)
- take_action  out  2**IR_W  one-hot pulse: popped command, ir==i, data[ACT_BIT]=1
- take_no_action  out  2**IR_W  one-hot pulse: popped command, ir==i, data[ACT_BIT]=0
- overflow  out  1  sticky: a command was dropped
- arm_done  out  1  high once the post-reset mask has expired

Behaviour:
- Reset:
  - Async assert; all flops clear.
  - All outputs 0, including jdo, cmd_ir, take_*, cmd_valid, overflow and arm_done.
  - Queue empty.
- Synchroniser:
  - Each strobe passes through SYNC_STAGES flops and then one edge flop.
  - A rising edge gives a 1-cycle upd_ir/upd_dr pulse SYNC_STAGES+1 clk cycles after the input rises.
  - Falling edges are ignored.
- Post-reset arm:
  - A counter masks edge pulses for the first SYNC_STAGES+1 cycles after reset deassertion, so an already-high strobe produces no pulse.
  - arm_done rises when the mask expires.
- upd_ir: ir_q <= ir_in.
- upd_dr: push {ir_q, sr}. If upd_ir and upd_dr coincide, the push uses the new ir_in.
- Handshake:
  - pop = cmd_valid & cmd_ready.
  - cmd_valid and cmd_ir reflect the head combinationally from registers.
  - On pop, registered outputs update next cycle: jdo <= head data, and exactly one bit of take_action or take_no_action is 1 for one cycle.
  - With no pop, take_* are 0 and jdo holds its value.
- Full:
  - push & full & !pop: the command is dropped, the queue is unchanged and overflow is set.
  - push & full & pop: accepted, occupancy unchanged.
- Empty: a push on an empty queue gives cmd_valid the next cycle. There is no same-cycle bypass, so the minimum latency from an input edge to cmd_valid is SYNC_STAGES+2 cycles.
- overflow: ovf_clr clears it. If ovf_clr coincides with a new drop, overflow stays set (set wins).
- Pointers: log2(FIFO_DEPTH) bits plus a wrap bit; full = same index, different wrap.

Optional Feature:
- NIOS2_JTAG_CMD_FIFO_EN defined: queue of FIFO_DEPTH entries as above.
- Undefined: single holding register (depth 1) with identical handshake and overflow rules; FIFO_DEPTH is ignored.

Decomposition:
- Package nios2_jtag_dbg_pkg holds:
  - the cmd_t struct {ir, data} sized from IR_W and SR_W
  - default width constants
  - IR code constants: OCIMEM=0, TRACEMEM=1, BREAK=2, TRACECTRL=3
- Sub-module nios2_jtag_strobe_sync: synchroniser, edge detect and arm mask. Instantiated twice (uir, udr).

Test Plan:
- Reset release with vs_udr held high:
  - no take_* pulse and cmd_valid stays 0
  - arm_done rises at cycle 3 (SYNC_STAGES=2)
- ir_in=2, vs_uir pulse; then sr=38'h04_0000_1234 (bit34=1), vs_udr pulse; cmd_ready=1:
  - cmd_valid 4 cycles after the udr rise
  - next cycle take_action=4'b0100 for 1 cycle and jdo=38'h04_0000_1234
- ir_in=0, sr bit34=0, cmd_ready=1:
  - take_no_action=4'b0001 for 1 cycle
  - take_action stays 0
- cmd_ready=0, 5 DR updates with FIFO_DEPTH=4:
  - 4 queued and overflow=1
  - then cmd_ready=1 pops the first 4 commands in order
  - ovf_clr drops overflow to 0
- Queue full, and a push coincides with a pop:
  - overflow stays 0, occupancy stays 4, the new command is last out
- Macro undefined, cmd_ready=0, 2 updates:
  - the first command is held and the second is dropped
  - overflow=1 and jdo equals the first sr after the pop

Source files
------------

// File: rtl/nios2_jtag_dbg_pkg.sv
// nios2_jtag_dbg_pkg: shared default widths, command record and IR codes for the JTAG debug bridge
// No ports. cmd_t is the default-width {ir, data} command; parametrised users declare
// their own record of the same shape.
package nios2_jtag_dbg_pkg;
    localparam int IR_W_DEF        = 2;
    localparam int SR_W_DEF        = 38;
    localparam int ACT_BIT_DEF     = 34;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int FIFO_DEPTH_DEF  = 4;
    localparam logic [IR_W_DEF-1:0] IR_OCIMEM    = 2'd0;
    localparam logic [IR_W_DEF-1:0] IR_TRACEMEM  = 2'd1;
    localparam logic [IR_W_DEF-1:0] IR_BREAK     = 2'd2;
    localparam logic [IR_W_DEF-1:0] IR_TRACECTRL = 2'd3;
    typedef struct packed {
        logic [IR_W_DEF-1:0] ir;
        logic [SR_W_DEF-1:0] data;
    } cmd_t;
endpackage

// File: rtl/nios2_jtag_strobe_sync.sv
// nios2_jtag_strobe_sync: synchronise an async TCK-domain strobe and emit a masked rising-edge pulse
// Ports: clk, reset_n (async active-low), strobe (async level in),
//        pulse (1-cycle registered rising-edge pulse), armed (post-reset mask expired).
module nios2_jtag_strobe_sync
    import nios2_jtag_dbg_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic strobe,
    output logic pulse,
    output logic armed
);
    localparam int CW = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0] ARM_CNT = CW'(SYNC_STAGES + 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] sync;
    logic                   last;
    logic [CW-1:0]          cnt;

    // The mask lasts exactly as long as the chain takes to fill, so a strobe already
    // high at reset release reaches the edge flop before pulses are allowed.
    assign armed = cnt == ARM_CNT;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync  <= '0;
            last  <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], strobe};
            last  <= sync[SYNC_STAGES-1];
            pulse <= armed & sync[SYNC_STAGES-1] & ~last;
            if (!armed) cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/nios2_jtag_debug_cmd_bridge.sv
// nios2_jtag_debug_cmd_bridge: system-clock side of the JTAG debug module, queues DR updates as commands
// Ports: clk, reset_n (async active-low); vs_uir/vs_udr async update strobes; ir_in, sr capture data;
//        cmd_ready/cmd_valid/cmd_ir head handshake; jdo, take_action, take_no_action registered
//        per-pop outputs; overflow sticky drop flag cleared by ovf_clr; arm_done post-reset mask done.
// Macro NIOS2_JTAG_CMD_FIFO_EN: FIFO_DEPTH-entry queue; undefined: single holding register.
module nios2_jtag_debug_cmd_bridge
    import nios2_jtag_dbg_pkg::*;
#(
    parameter int IR_W        = IR_W_DEF,
    parameter int SR_W        = SR_W_DEF,
    parameter int ACT_BIT     = ACT_BIT_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 vs_uir,
    input  logic                 vs_udr,
    input  logic [IR_W-1:0]      ir_in,
    input  logic [SR_W-1:0]      sr,
    input  logic                 cmd_ready,
    input  logic                 ovf_clr,
    output logic                 cmd_valid,
    output logic [IR_W-1:0]      cmd_ir,
    output logic [SR_W-1:0]      jdo,
    output logic [2**IR_W-1:0]   take_action,
    output logic [2**IR_W-1:0]   take_no_action,
    output logic                 overflow,
    output logic                 arm_done
);
    localparam int NCH = 2**IR_W;

    if (ACT_BIT >= SR_W) begin : g_bad_act
        $error("ACT_BIT must be below SR_W");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2, at least 2");
    end

    // Same shape as the package cmd_t, but sized from this instance's parameters.
    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [SR_W-1:0] data;
    } entry_t;

    logic            upd_ir, upd_dr, arm_ir, arm_dr, full, pop, push;
    logic [IR_W-1:0] ir_q;
    logic [NCH-1:0]  sel;
    entry_t          head, wr;

    nios2_jtag_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
        .clk(clk), .reset_n(reset_n), .strobe(vs_uir), .pulse(upd_ir), .armed(arm_ir)
    );
    nios2_jtag_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
        .clk(clk), .reset_n(reset_n), .strobe(vs_udr), .pulse(upd_dr), .armed(arm_dr)
    );

    assign arm_done = arm_ir & arm_dr;
    assign push     = upd_dr;
    assign pop      = cmd_valid & cmd_ready;
    // A coincident IR update must tag this command, so bypass the stale ir_q.
    assign wr       = '{ir: upd_ir ? ir_in : ir_q, data: sr};
    assign cmd_ir   = head.ir;
    assign sel      = NCH'(1) << head.ir;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ir_q <= '0;
        else if (upd_ir) ir_q <= ir_in;
    end

`ifdef NIOS2_JTAG_CMD_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    entry_t        mem [FIFO_DEPTH];
    logic [AW:0]   wp, rp;

    assign head      = mem[rp[AW-1:0]];
    assign cmd_valid = wp != rp;
    assign full      = wp == {~rp[AW], rp[AW-1:0]};

    // When full, a same-cycle pop frees the slot being written; the head is read
    // combinationally before the write lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp <= '0;
            rp <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push & (~full | pop)) begin
                mem[wp[AW-1:0]] <= wr;
                wp              <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
        end
    end
`else
    entry_t hold;
    logic   held;

    assign head      = hold;
    assign cmd_valid = held;
    assign full      = held;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold <= '0;
            held <= 1'b0;
        end else if (push & (~full | pop)) begin
            hold <= wr;
            held <= 1'b1;
        end else if (pop) begin
            held <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jdo            <= '0;
            take_action    <= '0;
            take_no_action <= '0;
            overflow       <= 1'b0;
        end else begin
            take_action    <= (pop & head.data[ACT_BIT]) ? sel : '0;
            take_no_action <= (pop & ~head.data[ACT_BIT]) ? sel : '0;
            if (pop) jdo <= head.data;
            // Set wins over a coincident clear.
            overflow <= (push & full & ~pop) | (overflow & ~ovf_clr);
        end
    end
endmodule

// File: tb/tb_nios2_jtag_debug_cmd_bridge.sv
// tb_nios2_jtag_debug_cmd_bridge: directed self-checking bench for the JTAG debug command bridge
module tb_nios2_jtag_debug_cmd_bridge;
    import nios2_jtag_dbg_pkg::*;

    localparam int SR_W = 38;
    localparam int ACT  = 34;
`ifdef NIOS2_JTAG_CMD_FIFO_EN
    localparam int QD = 4;
`else
    localparam int QD = 1;
`endif

    logic            clk, reset_n, vs_uir, vs_udr, cmd_ready, ovf_clr;
    logic [1:0]      ir_in, cmd_ir;
    logic [SR_W-1:0] sr, jdo;
    logic [3:0]      take_action, take_no_action;
    logic            cmd_valid, overflow, arm_done;

    int n_cmp = 0;
    int n_bad = 0;

    nios2_jtag_debug_cmd_bridge #(
        .IR_W(2), .SR_W(SR_W), .ACT_BIT(ACT), .SYNC_STAGES(2), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir), .vs_udr(vs_udr),
        .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready), .ovf_clr(ovf_clr),
        .cmd_valid(cmd_valid), .cmd_ir(cmd_ir), .jdo(jdo),
        .take_action(take_action), .take_no_action(take_no_action),
        .overflow(overflow), .arm_done(arm_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_pop(input string tag, input cmd_t c);
        logic [3:0] oh;
        oh = 4'(1) << c.ir;
        check({tag, "_jdo"}, jdo, c.data);
        check({tag, "_ta"}, take_action, c.data[ACT] ? oh : 4'b0);
        check({tag, "_tna"}, take_no_action, c.data[ACT] ? 4'b0 : oh);
    endtask

    task automatic ir_set(input logic [1:0] v);
        ir_in  = v;
        vs_uir = 1'b1;
        cyc(4);
        vs_uir = 1'b0;
        cyc(2);
    endtask

    // Returns at the negedge after the push edge (cmd_valid just updated).
    task automatic dr_rise(input logic [SR_W-1:0] v);
        sr     = v;
        vs_udr = 1'b1;
        cyc(4);
        vs_udr = 1'b0;
    endtask

    cmd_t            exp_q[$];
    cmd_t            c;
    logic [SR_W-1:0] d;
    logic            seen;

    initial begin
        reset_n = 1'b0; vs_uir = 1'b0; vs_udr = 1'b1; ir_in = '0; sr = '0;
        cmd_ready = 1'b0; ovf_clr = 1'b0;
        cyc(2);
        check("rst_valid", cmd_valid, 0);
        check("rst_ir", cmd_ir, 0);
        check("rst_jdo", jdo, 0);
        check("rst_ta", take_action, 0);
        check("rst_tna", take_no_action, 0);
        check("rst_ovf", overflow, 0);
        check("rst_arm", arm_done, 0);

        // vs_udr already high at release must not produce a command.
        reset_n = 1'b1;
        cyc(1); check("arm_c1", arm_done, 0);
        cyc(1); check("arm_c2", arm_done, 0);
        cyc(1); check("arm_c3", arm_done, 1);
        seen = 1'b0;
        repeat (8) begin
            cyc(1);
            seen |= cmd_valid | (|take_action) | (|take_no_action);
        end
        check("masked_quiet", seen, 0);
        vs_udr = 1'b0;
        cyc(3);

        // Latency and action pulse.
        ir_set(IR_BREAK);
        cmd_ready = 1'b1;
        sr = 38'h04_0000_1234;
        vs_udr = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cyc(1);
            check($sformatf("lat_c%0d", i), cmd_valid, 0);
        end
        cyc(1);
        check("lat_valid", cmd_valid, 1);
        check("lat_ir", cmd_ir, IR_BREAK);
        vs_udr = 1'b0;
        cyc(1);
        c.ir = IR_BREAK; c.data = 38'h04_0000_1234;
        check_pop("act", c);
        check("act_valid", cmd_valid, 0);
        cyc(1);
        check("act_end", take_action, 0);
        check("act_jdo_hold", jdo, 38'h04_0000_1234);

        // No-action pulse.
        ir_set(IR_OCIMEM);
        dr_rise(38'h00_dead_beef);
        cyc(1);
        c.ir = IR_OCIMEM; c.data = 38'h00_dead_beef;
        check_pop("noact", c);
        cyc(1);
        check("noact_end", take_no_action, 0);
        cmd_ready = 1'b0;
        cyc(2);

        // Overflow: QD+1 updates with no consumer; the last is dropped.
        ir_set(IR_TRACEMEM);
        for (int i = 0; i <= QD; i++) begin
            d = 38'h100 + SR_W'(i);
            d[ACT] = i[0];
            dr_rise(d);
            if (i < QD) begin
                c.ir = IR_TRACEMEM; c.data = d;
                exp_q.push_back(c);
            end
            cyc(2);
        end
        check("ovf_set", overflow, 1);
        check("ovf_valid", cmd_valid, 1);
        check("ovf_head_ir", cmd_ir, IR_TRACEMEM);
        cmd_ready = 1'b1;
        for (int i = 0; i < QD; i++) begin
            cyc(1);
            check_pop($sformatf("ovf_pop%0d", i), exp_q[i]);
        end
        cmd_ready = 1'b0;
        check("ovf_drained", cmd_valid, 0);
        check("ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        check("ovf_clr", overflow, 0);
        exp_q.delete();

        // Full queue: a push coinciding with a pop is accepted.
        ir_set(IR_TRACECTRL);
        for (int i = 0; i < QD; i++) begin
            d = 38'h200 + SR_W'(i);
            d[ACT] = ~i[0];
            dr_rise(d);
            c.ir = IR_TRACECTRL; c.data = d;
            exp_q.push_back(c);
            cyc(2);
        end
        d = 38'h04_0000_0300;
        sr = d;
        vs_udr = 1'b1;
        cyc(3);
        cmd_ready = 1'b1;
        cyc(1);
        cmd_ready = 1'b0;
        vs_udr = 1'b0;
        check_pop("cp_first", exp_q.pop_front());
        c.ir = IR_TRACECTRL; c.data = d;
        exp_q.push_back(c);
        check("cp_ovf", overflow, 0);
        check("cp_valid", cmd_valid, 1);
        cyc(1);
        check("cp_idle", take_action | take_no_action, 0);
        cmd_ready = 1'b1;
        for (int i = 0; i < QD; i++) begin
            cyc(1);
            check_pop($sformatf("cp_pop%0d", i), exp_q[i]);
        end
        cmd_ready = 1'b0;
        check("cp_drained", cmd_valid, 0);
        check("cp_ovf_end", overflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
